// File: rtl/load_store_unit.sv
// Load/store unit between the execute stage and a byte-addressable data memory.
// Optional macro LSU_MISALIGN_TRAP_EN turns misaligned half/word accesses into error responses.
module load_store_unit #(
    parameter int AWIDTH = 32,
    parameter int DPORT  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic [DPORT-1:0]  req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DPORT-1:0]  rsp_rdata,
    output logic              rsp_err,
    output logic              mem_wr,
    output logic [1:0]        mem_size,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DPORT-1:0]  mem_wdata,
    input  logic [DPORT-1:0]  mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic              we_r;
    logic [2:0]        funct3_r;
    logic [AWIDTH-1:0] addr_r;
    logic [DPORT-1:0]  wdata_r;
    logic [DPORT-1:0]  rdata_r;
    logic              err_r;
    logic              fault_s;

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        case (f3)
            3'b000, 3'b001, 3'b010: ok = 1'b1;
            3'b100, 3'b101:         ok = ~we;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

`ifdef LSU_MISALIGN_TRAP_EN
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        logic mis;
        case (f3[1:0])
            2'b01:   mis = a[0];
            2'b10:   mis = (a != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction
`endif

    function automatic logic [DPORT-1:0] load_extend(input logic [2:0] f3,
                                                     input logic [DPORT-1:0] raw);
        logic [DPORT-1:0] ext;
        case (f3)
            3'b000:  ext = {{(DPORT-8){raw[7]}}, raw[7:0]};
            3'b001:  ext = {{(DPORT-16){raw[15]}}, raw[15:0]};
            3'b010:  ext = raw;
            3'b100:  ext = {{(DPORT-8){1'b0}}, raw[7:0]};
            3'b101:  ext = {{(DPORT-16){1'b0}}, raw[15:0]};
            default: ext = '0;
        endcase
        return ext;
    endfunction

    // Fault decode for the request held in the registers
    always_comb begin
        fault_s = ~f3_legal(we_r, funct3_r);
`ifdef LSU_MISALIGN_TRAP_EN
        if (misaligned(funct3_r, addr_r[1:0])) begin
            fault_s = 1'b1;
        end else begin
            fault_s = fault_s;
        end
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    state_s = ACCESS;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCESS: state_s = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Output decode; memory strobes depend only on state so reset kills them at once
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        mem_wr    = 1'b0;
        mem_size  = 2'd0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_r)
            IDLE:   req_ready = 1'b1;
            ACCESS: begin
                mem_wr    = we_r & ~fault_s;
                mem_size  = funct3_r[1:0];
                mem_addr  = addr_r;
                mem_wdata = wdata_r;
            end
            RESP:   rsp_valid = 1'b1;
            default: req_ready = 1'b0;
        endcase
    end

    // Request capture and response data registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_r     <= 1'b0;
            funct3_r <= 3'd0;
            addr_r   <= '0;
            wdata_r  <= '0;
            rdata_r  <= '0;
            err_r    <= 1'b0;
        end else if (state_r == IDLE && req_valid) begin
            we_r     <= req_we;
            funct3_r <= req_funct3;
            addr_r   <= req_addr;
            wdata_r  <= req_wdata;
        end else if (state_r == ACCESS) begin
            rdata_r  <= (!we_r && !fault_s) ? load_extend(funct3_r, mem_rdata) : '0;
            err_r    <= fault_s;
        end else begin
            rdata_r  <= rdata_r;
            err_r    <= err_r;
        end
    end

    assign rsp_rdata = rdata_r;
    assign rsp_err   = err_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a 256-byte memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [7:0]  mem [256];
    int          wr_cnt = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        acc_wr;
    logic [31:0] acc_addr;
    logic [1:0]  acc_size;
    logic [31:0] acc_wdata;

    load_store_unit #(.AWIDTH(32), .DPORT(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .mem_wr(mem_wr), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Combinational little-endian read port
    always_comb begin
        logic [7:0] ma;
        ma = mem_addr[7:0];
        mem_rdata = {mem[ma + 8'd3], mem[ma + 8'd2], mem[ma + 8'd1], mem[ma]};
    end

    // Memory write port and write-strobe counter
    always @(posedge clk) begin
        if (mem_wr) begin
            wr_cnt <= wr_cnt + 1;
            mem[mem_addr[7:0]] <= mem_wdata[7:0];
            if (mem_size != 2'd0) mem[mem_addr[7:0] + 8'd1] <= mem_wdata[15:8];
            if (mem_size == 2'd2) begin
                mem[mem_addr[7:0] + 8'd2] <= mem_wdata[23:16];
                mem[mem_addr[7:0] + 8'd3] <= mem_wdata[31:24];
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        rsp_ready = 1'b1;
        check_eq("req_ready_idle", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        acc_wr = mem_wr; acc_addr = mem_addr; acc_size = mem_size; acc_wdata = mem_wdata;
        check_eq("rsp_early", {31'd0, rsp_valid}, 32'd0);
        n = 1;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("rsp_lat", 32'(n), 32'd2);
        rd = rsp_rdata;
        er = rsp_err;
        @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          c;
        for (int i = 0; i < 256; i++) mem[i] = 8'd0;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0;
        #12;
        check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check_eq("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'd0);
        check_eq("rst_rdata", rsp_rdata, 32'd0);
        check_eq("rst_err", {31'd0, rsp_err}, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Test 1: SW then LW
        c = wr_cnt;
        xact(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er);
        check_eq("sw_acc_wr", {31'd0, acc_wr}, 32'd1);
        check_eq("sw_acc_addr", acc_addr, 32'h10);
        check_eq("sw_acc_size", {30'd0, acc_size}, 32'd2);
        check_eq("sw_acc_wdata", acc_wdata, 32'hDEADBEEF);
        check_eq("sw_wr_once", 32'(wr_cnt - c), 32'd1);
        check_eq("sw_rdata", rd, 32'd0);
        check_eq("sw_err", {31'd0, er}, 32'd0);
        xact(1'b0, 3'b010, 32'h10, 32'd0, rd, er);
        check_eq("lw_rdata", rd, 32'hDEADBEEF);
        check_eq("lw_err", {31'd0, er}, 32'd0);
        check_eq("lw_no_wr", {31'd0, acc_wr}, 32'd0);

        // Test 2: sign/zero extension
        xact(1'b0, 3'b000, 32'h13, 32'd0, rd, er); check_eq("lb", rd, 32'hFFFFFFDE);
        xact(1'b0, 3'b100, 32'h13, 32'd0, rd, er); check_eq("lbu", rd, 32'h000000DE);
        xact(1'b0, 3'b001, 32'h10, 32'd0, rd, er); check_eq("lh", rd, 32'hFFFFBEEF);
        xact(1'b0, 3'b101, 32'h10, 32'd0, rd, er); check_eq("lhu", rd, 32'h0000BEEF);

        // Test 3: SB only touches one byte
        c = wr_cnt;
        xact(1'b1, 3'b000, 32'h11, 32'h00000055, rd, er);
        check_eq("sb_size", {30'd0, acc_size}, 32'd0);
        check_eq("sb_wr_once", 32'(wr_cnt - c), 32'd1);
        xact(1'b0, 3'b010, 32'h10, 32'd0, rd, er); check_eq("lw_after_sb", rd, 32'hDEAD55EF);

        // Test 4: backpressure with a second request waiting
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_funct3 = 3'b100; req_addr = 32'h13;
        @(negedge clk);
        check_eq("bp_first_valid", {31'd0, rsp_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
            check_eq("bp_hold_rdata", rsp_rdata, 32'hDEAD55EF);
            check_eq("bp_hold_ready", {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("bp_after_hs_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("bp_after_hs_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check_eq("bp_second_access", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        check_eq("bp_second_valid", {31'd0, rsp_valid}, 32'd1);
        check_eq("bp_second_rdata", rsp_rdata, 32'h000000DE);
        @(posedge clk);

        // Test 5: illegal funct3
        c = wr_cnt;
        xact(1'b0, 3'b011, 32'h10, 32'd0, rd, er);
        check_eq("ill_ld_err", {31'd0, er}, 32'd1);
        check_eq("ill_ld_rdata", rd, 32'd0);
        xact(1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, rd, er);
        check_eq("ill_st_err", {31'd0, er}, 32'd1);
        check_eq("ill_st_rdata", rd, 32'd0);
        check_eq("ill_no_wr", 32'(wr_cnt - c), 32'd0);
        xact(1'b0, 3'b010, 32'h10, 32'd0, rd, er); check_eq("ill_mem_intact", rd, 32'hDEAD55EF);

        // Test 6: misaligned halfword store
        c = wr_cnt;
        xact(1'b1, 3'b001, 32'h21, 32'h0000A5C3, rd, er);
`ifdef LSU_MISALIGN_TRAP_EN
        check_eq("mis_sh_err", {31'd0, er}, 32'd1);
        check_eq("mis_sh_no_wr", 32'(wr_cnt - c), 32'd0);
        xact(1'b0, 3'b100, 32'h21, 32'd0, rd, er); check_eq("mis_lbu", rd, 32'd0);
`else
        check_eq("mis_sh_err", {31'd0, er}, 32'd0);
        check_eq("mis_sh_wr", 32'(wr_cnt - c), 32'd1);
        xact(1'b0, 3'b101, 32'h21, 32'd0, rd, er); check_eq("mis_lhu", rd, 32'h0000A5C3);
        check_eq("mis_lhu_err", {31'd0, er}, 32'd0);
`endif

        // Reset during the ACCESS cycle of a store
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h30;
        req_wdata = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check_eq("rst_acc_wr_before", {31'd0, mem_wr}, 32'd1);
        c = wr_cnt;
        rst_n = 1'b0;
        #1;
        check_eq("rst_acc_wr_drop", {31'd0, mem_wr}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("rst_acc_no_wr", 32'(wr_cnt - c), 32'd0);
        check_eq("rst_acc_ready", {31'd0, req_ready}, 32'd1);
        check_eq("rst_acc_valid", {31'd0, rsp_valid}, 32'd0);
        xact(1'b0, 3'b010, 32'h30, 32'd0, rd, er); check_eq("rst_acc_mem", rd, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
